// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates COUNT_N adder results per batch into a
// wrapping ACC_W-bit total with sticky overflow, delivered on valid/ready.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous batch abort
//   sum_in     in   5-bit unsigned sample
//   in_valid   in   sample valid
//   in_ready   out  block accepts samples (ACCUM state)
//   acc_out    out  running / completed total
//   overflow   out  sticky, total exceeded 2^ACC_W-1
//   cnt        out  samples accepted in current batch
//   out_valid  out  acc_out holds a completed batch (DONE state)
//   out_ready  in   downstream takes the result
module sum_accumulator #(
    parameter int COUNT_N = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [4:0]       sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic [7:0]       cnt,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    // One extra bit so the carry out of the wrap is visible.
    logic [ACC_W:0]     sum_ext;
    logic [7:0]         cnt_inc;

    assign sum_ext = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, sum_in};
    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = sum_ext[ACC_W-1:0];
                        ovf_d = ovf_q | sum_ext[ACC_W];
                        cnt_d = cnt_inc;
                        if (cnt_inc == 8'(COUNT_N))
                            state_d = DONE;
                    end
                end
                DONE: begin
                    // Result consumed: start the next batch empty.
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign cnt       = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed vector table plus hand sequences for
// wrap/overflow, COUNT_N=1 and asynchronous reset.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst, clr, in_valid, out_ready;
    logic [4:0] sum_in;

    logic       a_ir, a_ovf, a_ov;
    logic [7:0] a_acc, a_cnt;
    logic       b_ir, b_ovf, b_ov;
    logic [5:0] b_acc;
    logic [7:0] b_cnt;
    logic       c_ir, c_ovf, c_ov;
    logic [4:0] c_acc;
    logic [7:0] c_cnt;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.COUNT_N(4), .ACC_W(8)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .sum_in(sum_in),
        .in_valid(in_valid), .in_ready(a_ir), .acc_out(a_acc),
        .overflow(a_ovf), .cnt(a_cnt), .out_valid(a_ov),
        .out_ready(out_ready)
    );

    sum_accumulator #(.COUNT_N(4), .ACC_W(6)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .sum_in(sum_in),
        .in_valid(in_valid), .in_ready(b_ir), .acc_out(b_acc),
        .overflow(b_ovf), .cnt(b_cnt), .out_valid(b_ov),
        .out_ready(out_ready)
    );

    sum_accumulator #(.COUNT_N(1), .ACC_W(5)) u_c (
        .clk(clk), .rst(rst), .clr(clr), .sum_in(sum_in),
        .in_valid(in_valid), .in_ready(c_ir), .acc_out(c_acc),
        .overflow(c_ovf), .cnt(c_cnt), .out_valid(c_ov),
        .out_ready(out_ready)
    );

    typedef struct {
        logic       clr;
        logic       iv;
        logic [4:0] s;
        logic       ordy;
        logic [7:0] acc;
        logic [7:0] cnt;
        logic       ovf;
        logic       ov;
        logic       ir;
    } tv_t;

    tv_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic v,
                         input logic [4:0] s, input logic r);
        clr = c; in_valid = v; sum_in = s; out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string n, input int acc, input int cn,
                         input int ovf, input int ov, input int ir);
        chk({n, ".acc"}, a_acc, acc);
        chk({n, ".cnt"}, a_cnt, cn);
        chk({n, ".ovf"}, a_ovf, ovf);
        chk({n, ".ov"},  a_ov,  ov);
        chk({n, ".ir"},  a_ir,  ir);
    endtask

    task automatic add(input logic c, input logic v, input logic [4:0] s,
                       input logic r, input int acc, input int cn,
                       input logic ovf, input logic ov, input logic ir);
        tv_t t;
        t.clr = c; t.iv = v; t.s = s; t.ordy = r;
        t.acc = 8'(acc); t.cnt = 8'(cn);
        t.ovf = ovf; t.ov = ov; t.ir = ir;
        vecs.push_back(t);
    endtask

    initial begin
        // nominal batch of 31s
        add(0, 1, 31, 0,  31, 1, 0, 0, 1);
        add(0, 1, 31, 0,  62, 2, 0, 0, 1);
        add(0, 1, 31, 0,  93, 3, 0, 0, 1);
        add(0, 1, 31, 0, 124, 4, 0, 1, 0);
        add(0, 0,  0, 1,   0, 0, 0, 0, 1);
        // backpressure
        add(0, 1,  1, 0,   1, 1, 0, 0, 1);
        add(0, 1,  2, 0,   3, 2, 0, 0, 1);
        add(0, 1,  3, 0,   6, 3, 0, 0, 1);
        add(0, 1,  4, 0,  10, 4, 0, 1, 0);
        add(0, 1,  7, 0,  10, 4, 0, 1, 0);
        add(0, 1,  7, 0,  10, 4, 0, 1, 0);
        add(0, 1,  7, 0,  10, 4, 0, 1, 0);
        add(0, 1,  7, 1,   0, 0, 0, 0, 1);
        add(0, 1,  7, 0,   7, 1, 0, 0, 1);
        add(1, 0,  0, 0,   0, 0, 0, 0, 1);
        // input gaps, out_ready ignored in ACCUM
        add(0, 1,  5, 1,   5, 1, 0, 0, 1);
        add(0, 0,  9, 1,   5, 1, 0, 0, 1);
        add(0, 0,  9, 0,   5, 1, 0, 0, 1);
        add(0, 1, 10, 0,  15, 2, 0, 0, 1);
        add(0, 1,  0, 0,  15, 3, 0, 0, 1);
        add(0, 1, 16, 0,  31, 4, 0, 1, 0);
        add(0, 0,  0, 1,   0, 0, 0, 0, 1);
        // clr mid-batch drops the concurrent sample
        add(0, 1, 10, 0,  10, 1, 0, 0, 1);
        add(0, 1, 10, 0,  20, 2, 0, 0, 1);
        add(1, 1,  9, 0,   0, 0, 0, 0, 1);
        add(0, 1,  9, 0,   9, 1, 0, 0, 1);
        add(0, 1,  1, 0,  10, 2, 0, 0, 1);
        add(0, 1,  1, 0,  11, 3, 0, 0, 1);
        add(0, 1,  1, 0,  12, 4, 0, 1, 0);
        // clr in DONE discards without handshake
        add(1, 0,  0, 0,   0, 0, 0, 0, 1);
        add(0, 1,  2, 0,   2, 1, 0, 0, 1);
        add(0, 1,  2, 0,   4, 2, 0, 0, 1);
        add(0, 1,  2, 0,   6, 3, 0, 0, 1);
        add(0, 1,  2, 0,   8, 4, 0, 1, 0);
        // clr beats out_ready
        add(1, 0,  0, 1,   0, 0, 0, 0, 1);

        rst = 1'b1;
        drive(0, 0, 0, 0);
        #2;
        chk_a("rst", 0, 0, 0, 0, 1);
        #10 rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].iv, vecs[i].s, vecs[i].ordy);
            step();
            chk_a($sformatf("v%0d", i), int'(vecs[i].acc),
                  int'(vecs[i].cnt), int'(vecs[i].ovf),
                  int'(vecs[i].ov), int'(vecs[i].ir));
        end

        // wrap and overflow on ACC_W=6
        drive(1, 0, 0, 0);
        step();
        drive(0, 1, 31, 0);
        step();
        chk("wrap1.acc", b_acc, 31);
        chk("wrap1.ovf", b_ovf, 0);
        step();
        chk("wrap2.acc", b_acc, 62);
        chk("wrap2.ovf", b_ovf, 0);
        step();
        chk("wrap3.acc", b_acc, 29);
        chk("wrap3.ovf", b_ovf, 1);
        step();
        chk("wrap4.acc", b_acc, 60);
        chk("wrap4.ovf", b_ovf, 1);
        chk("wrap4.ov",  b_ov,  1);
        chk("wrap4.cnt", b_cnt, 4);
        chk("wrap4.a_acc", a_acc, 124);
        drive(0, 0, 0, 1);
        step();
        chk("wrapclr.ovf", b_ovf, 0);
        chk("wrapclr.acc", b_acc, 0);

        // COUNT_N=1: every accept completes
        drive(1, 0, 0, 0);
        step();
        drive(0, 1, 20, 0);
        step();
        chk("n1.acc", c_acc, 20);
        chk("n1.ov",  c_ov,  1);
        chk("n1.ir",  c_ir,  0);
        chk("n1.cnt", c_cnt, 1);
        drive(0, 0, 0, 1);
        step();
        chk("n1clr.ov",  c_ov,  0);
        chk("n1clr.acc", c_acc, 0);
        drive(0, 1, 31, 0);
        step();
        chk("n1b.acc", c_acc, 31);
        chk("n1b.ovf", c_ovf, 0);
        chk("n1b.ov",  c_ov,  1);

        // async reset mid-batch
        drive(1, 0, 0, 0);
        step();
        drive(0, 1, 6, 0);
        step();
        step();
        chk_a("pre", 12, 2, 0, 0, 1);
        #3 rst = 1'b1;
        #1;
        chk_a("arst", 0, 0, 0, 0, 1);
        step();
        step();
        chk_a("hold", 0, 0, 0, 0, 1);
        #3 rst = 1'b0;
        drive(0, 1, 3, 0);
        step();
        chk_a("resume", 3, 1, 0, 0, 1);

        // async reset in DONE
        step();
        step();
        step();
        chk_a("done", 12, 4, 0, 1, 0);
        #3 rst = 1'b1;
        #1;
        chk_a("arstd", 0, 0, 0, 0, 1);
        chk("arstd.b_ov", b_ov, 0);
        #2 rst = 1'b0;
        drive(0, 0, 0, 0);
        step();
        chk_a("idle", 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
